teclado_tx: RTL and testbench

//  PS/2 host-to-device transmitter; companion to the keyboard receiver path. Sends one command byte
//  (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard over the open-drain ps2c/ps2d lines.

---
 rtl/teclado_pkg.sv | 40 ++++
 rtl/ps2_filtro.sv | 83 ++++++++
 rtl/teclado_tx.sv | 272 +++++++++++++++++++++++++++
 tb/tb_teclado_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/teclado_pkg.sv
`default_nettype none
// ============================================================================
// Module      : teclado_pkg
// Description : Shared definitions for the PS/2 keyboard host path. Holds the
//               transmitter FSM encodings, PS/2 frame bit positions, common
//               command bytes and small helper functions.
// Revision    : 1.0 - initial release
// Ports       : none (package)
// ============================================================================
package teclado_pkg;

  // Transmitter FSM encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Frame bit positions, counted in device clock falls after RTS
  localparam int DATA_BITS  = 8;
  localparam int PARITY_IDX = 9;
  localparam int STOP_IDX   = 10;

  // Common host-to-keyboard commands
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  // Counter width for a count range of n states; never narrower than 1 bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_filtro.sv
`default_nettype none
// ============================================================================
// Module      : ps2_filtro
// Description : PS/2 pin conditioning. Two-flop synchronizers on both pins,
//               a FILTER_LEN-sample glitch filter on the clock pin and a
//               one-cycle pulse when the filtered clock goes 1->0.
//               Shared by the transmitter and the receiver.
// Revision    : 1.0 - initial release
// Ports       : reloj        in  system clock
//               reset        in  synchronous reset, active-low
//               ps2c_i       in  raw PS/2 clock pin (asynchronous)
//               ps2d_i       in  raw PS/2 data pin (asynchronous)
//               ps2c_sync_o  out synchronized (unfiltered) clock level
//               ps2d_sync_o  out synchronized data level
//               fall_o       out 1-cycle pulse on filtered clock falling edge
// ============================================================================
module ps2_filtro
  import teclado_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic reloj,
  input  logic reset,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic ps2c_sync_o,
  output logic ps2d_sync_o,
  output logic fall_o
);

  localparam int                CNT_W    = cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             c_meta_q, c_sync_q;
  logic             d_meta_q, d_sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  // The counter tracks consecutive samples that disagree with the filtered
  // level; any agreeing sample restarts it, so short glitches never pass.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (c_sync_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = c_sync_q;
        fall_d = ~c_sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Idle PS/2 lines are high, so the pipeline resets to 1 to avoid a
  // spurious fall right after reset.
  always_ff @(posedge reloj) begin
    if (!reset) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
      filt_q   <= 1'b1;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
    end else begin
      c_meta_q <= ps2c_i;
      c_sync_q <= c_meta_q;
      d_meta_q <= ps2d_i;
      d_sync_q <= d_meta_q;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
    end
  end

  assign ps2c_sync_o = c_sync_q;
  assign ps2d_sync_o = d_sync_q;
  assign fall_o      = fall_q;

endmodule
`default_nettype wire

// File: rtl/teclado_tx.sv
`default_nettype none
// ============================================================================
// Module      : teclado_tx
// Description : PS/2 host-to-device transmitter. Inhibits the bus, issues a
//               request-to-send, shifts one command byte (LSB first, odd
//               parity, stop) on device-generated clock falls and checks the
//               device ACK. A watchdog aborts the transfer if the device
//               stops clocking.
//               Optional macro TECLADO_TX_RETRY_EN: the first NAK or timeout
//               of a command restarts the transfer from INHIBIT with the same
//               byte; only a second failure reports tx_err.
// Revision    : 1.0 - initial release
// Ports       : reloj    in  system clock
//               reset    in  synchronous reset, active-low
//               wr_en    in  1-cycle request to transmit din (ignored if busy)
//               din      in  command byte
//               ps2c_in  in  PS/2 clock pin level (asynchronous)
//               ps2d_in  in  PS/2 data pin level (asynchronous)
//               ps2c_oe  out 1 = pull ps2c low
//               ps2d_oe  out 1 = pull ps2d low
//               busy     out transfer in progress (receiver must ignore bus)
//               tx_done  out 1-cycle pulse: frame sent and ACK received
//               tx_err   out 1-cycle pulse: NAK or timeout
// Notes       : INHIBIT_CYCLES must be at least 2.
// ============================================================================
module teclado_tx
  import teclado_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int               INH_W    = cnt_width(INHIBIT_CYCLES);
  localparam int               TO_W     = cnt_width(TIMEOUT_CYCLES);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  // Conditioned pins
  logic c_sync, d_sync, fall;

  ps2_filtro #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filtro (
    .reloj       (reloj),
    .reset       (reset),
    .ps2c_i      (ps2c_in),
    .ps2d_i      (ps2d_in),
    .ps2c_sync_o (c_sync),
    .ps2d_sync_o (d_sync),
    .fall_o      (fall)
  );

  logic [2:0]       state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [3:0]       n_q, n_d;
  logic             c_oe_q, c_oe_d;
  logic             d_oe_q, d_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ack_ok_q, ack_ok_d;
`ifdef TECLADO_TX_RETRY_EN
  logic             retry_q, retry_d;
`endif

  logic       in_window;
  logic       timeout_hit;
  logic       fall_ok;
  logic       nak_hit;
  logic [3:0] n_next;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    inh_d    = inh_q;
    to_d     = to_q;
    n_d      = n_q;
    c_oe_d   = c_oe_q;
    d_oe_d   = d_oe_q;
    busy_d   = busy_q;
    ack_ok_d = ack_ok_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    nak_hit  = 1'b0;
`ifdef TECLADO_TX_RETRY_EN
    retry_d  = retry_q;
`endif
    n_next   = n_q + 4'd1;

    // The watchdog only runs while the device owns the clock.
    in_window   = (state_q == ST_RTS) || (state_q == ST_DATA) ||
                  (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
    timeout_hit = in_window && (to_q == TO_LAST);
    // An expiring timeout takes precedence over a coincident fall.
    fall_ok     = fall && !timeout_hit;

    if (in_window) begin
      if (timeout_hit || fall) to_d = '0;
      else                     to_d = to_q + TO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          data_d   = din;
          par_d    = odd_parity(din);
          state_d  = ST_INHIBIT;
          busy_d   = 1'b1;
          c_oe_d   = 1'b1;
          d_oe_d   = 1'b0;
          inh_d    = '0;
          ack_ok_d = 1'b0;
`ifdef TECLADO_TX_RETRY_EN
          retry_d  = 1'b0;
`endif
        end
      end

      ST_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          // Release the clock with data held low: request-to-send.
          state_d = ST_RTS;
          c_oe_d  = 1'b0;
          to_d    = '0;
          n_d     = 4'd0;
        end else begin
          inh_d = inh_q + INH_W'(1);
          // Start bit goes on the line during the last inhibit cycle.
          if (inh_q == INH_PRE) d_oe_d = 1'b1;
        end
      end

      ST_RTS, ST_DATA: begin
        if (fall_ok) begin
          state_d = ST_DATA;
          n_d     = n_next;
          if (n_next <= 4'(DATA_BITS)) begin
            // n_next[2:0]-1 wraps 8 back to index 7, giving bits 0..7.
            d_oe_d = ~data_q[n_next[2:0] - 3'd1];
          end else if (n_next == 4'(PARITY_IDX)) begin
            d_oe_d = ~par_q;
          end else begin
            // Stop bit: release data and wait for the device ACK.
            d_oe_d  = 1'b0;
            n_d     = 4'(STOP_IDX);
            state_d = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        if (fall_ok) begin
          if (!d_sync) begin
            ack_ok_d = 1'b1;
            state_d  = ST_WAIT_IDLE;
          end else begin
            nak_hit  = 1'b1;
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (c_sync && d_sync) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          done_d   = ack_ok_q;
          ack_ok_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        c_oe_d  = 1'b0;
        d_oe_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Failure handling overrides whatever the state decided above.
    if (timeout_hit || nak_hit) begin
      done_d = 1'b0;
`ifdef TECLADO_TX_RETRY_EN
      if (!retry_q) begin
        retry_d  = 1'b1;
        state_d  = ST_INHIBIT;
        inh_d    = '0;
        to_d     = '0;
        c_oe_d   = 1'b1;
        d_oe_d   = 1'b0;
        busy_d   = 1'b1;
        ack_ok_d = 1'b0;
      end else begin
`endif
        err_d = 1'b1;
        if (timeout_hit) begin
          state_d = ST_IDLE;
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b0;
          busy_d  = 1'b0;
        end else begin
          // NAK: the device still owns the bus until both lines idle.
          state_d  = ST_WAIT_IDLE;
          ack_ok_d = 1'b0;
        end
`ifdef TECLADO_TX_RETRY_EN
      end
`endif
    end
  end

  always_ff @(posedge reloj) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      par_q    <= 1'b0;
      inh_q    <= '0;
      to_q     <= '0;
      n_q      <= '0;
      c_oe_q   <= 1'b0;
      d_oe_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ack_ok_q <= 1'b0;
`ifdef TECLADO_TX_RETRY_EN
      retry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      par_q    <= par_d;
      inh_q    <= inh_d;
      to_q     <= to_d;
      n_q      <= n_d;
      c_oe_q   <= c_oe_d;
      d_oe_q   <= d_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ack_ok_q <= ack_ok_d;
`ifdef TECLADO_TX_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  assign ps2c_oe = c_oe_q;
  assign ps2d_oe = d_oe_q;
  assign busy    = busy_q;
  assign tx_done = done_q;
  assign tx_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_teclado_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_teclado_tx
// Description : Self-checking bench for teclado_tx. A behavioural PS/2 device
//               answers the host (ACK, NAK or silence); expected outcomes are
//               queued at stimulus time and compared by a monitor on every
//               tx_done / tx_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_teclado_tx;
  import teclado_pkg::*;

  localparam int INH = 1200;
  localparam int TO  = 20000;
  localparam int H   = 25;    // device clock half period in reloj cycles

  localparam int M_ACK    = 0;
  localparam int M_NAK    = 1;
  localparam int M_SILENT = 2;

  logic       reloj = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] din;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, busy, tx_done, tx_err;

  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  int         dev_mode = M_ACK;
  int         dev_fall_cnt = 0;
  logic [10:1] dev_frame = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] b;
    int         kind;
  } exp_t;
  exp_t exp_q[$];

  // Open-drain bus: either side pulls low
  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  always #5 reloj = ~reloj;
  always @(posedge reloj) cyc <= cyc + 1;

  teclado_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (8)
  ) dut (
    .reloj   (reloj),
    .reset   (reset),
    .wr_en   (wr_en),
    .din     (din),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .busy    (busy),
    .tx_done (tx_done),
    .tx_err  (tx_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Line levels the device should see after falls 1..10: data LSB first,
  // odd parity, then a released (high) stop bit.
  function automatic logic [10:1] model_frame(input logic [7:0] b);
    logic [10:1] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------- PS/2 device model ----------------
  initial begin
    forever begin
      while (ps2c_oe !== 1'b1) @(negedge reloj);
      while (ps2c_oe === 1'b1) @(negedge reloj);
      if (ps2d_oe !== 1'b1 || dev_mode == M_SILENT) continue;
      repeat (10) @(negedge reloj);
      for (int k = 1; k <= 11; k++) begin
        if (k == 11 && dev_mode == M_ACK) begin
          dev_d_low = 1'b1;
          repeat (2) @(negedge reloj);
        end
        dev_c_low    = 1'b1;
        dev_fall_cnt = k;
        repeat (H - 1) @(negedge reloj);
        if (k <= 10) dev_frame[k] = ps2d_in;
        @(negedge reloj);
        dev_c_low = 1'b0;
        repeat (H) @(negedge reloj);
        dev_d_low = 1'b0;
        if (busy !== 1'b1) break;
      end
      dev_c_low = 1'b0;
      dev_d_low = 1'b0;
    end
  end

  // ---------------- Scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge reloj);
      if (tx_done === 1'b1 || tx_err === 1'b1) begin
        chk("pulse_exclusive", 32'(tx_done & tx_err), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual done=%0b err=%0b required=no pulse", tx_done, tx_err);
        end else begin
          e = exp_q.pop_front();
          chk("outcome_done", 32'(tx_done), 32'(e.kind == M_ACK));
          if (e.kind != M_SILENT) chk("frame_bits", 32'(dev_frame), 32'(model_frame(e.b)));
          chk("busy_at_pulse", 32'(busy), 32'(e.kind == M_NAK));
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic send(input logic [7:0] b, input int mode, input bit push);
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 20000) begin @(negedge reloj); g++; end
    if (busy !== 1'b0) chk("idle_before_send", 32'(busy), 32'd0);
    dev_mode     = mode;
    dev_fall_cnt = 0;
    if (push) exp_q.push_back('{b, mode});
    din   = b;
    wr_en = 1'b1;
    @(negedge reloj);
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && g < budget) begin
      @(negedge reloj);
      g++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL completion actual pending=%0d busy=%0b required=pending 0 busy 0", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic wait_fall(input int k);
    int g;
    g = 0;
    while (dev_fall_cnt != k && g < 5000) begin @(negedge reloj); g++; end
    chk("reach_fall", 32'(dev_fall_cnt), 32'(k));
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_c_oe"}, 32'(ps2c_oe), 32'd0);
    chk({nm, "_d_oe"}, 32'(ps2d_oe), 32'd0);
    chk({nm, "_busy"}, 32'(busy),    32'd0);
    chk({nm, "_done"}, 32'(tx_done), 32'd0);
    chk({nm, "_err"},  32'(tx_err),  32'd0);
  endtask

  initial begin
    int t_fall, g;
    bit prev_c, seen;
    reset = 1'b0;
    wr_en = 1'b0;
    din   = 8'h00;
    repeat (3) @(negedge reloj);
    chk_quiet("reset");
    reset = 1'b1;
    repeat (20) @(negedge reloj);

    send(CMD_SET_LED, M_ACK, 1'b1); wait_done(8000);
    send(CMD_ENABLE,  M_ACK, 1'b1); wait_done(8000);
    send(8'h00,       M_NAK, 1'b1); wait_done(8000);
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), int'($urandom_range(0, 1)), 1'b1);
      wait_done(8000);
    end

    // Second request mid-frame must be ignored
    send(CMD_SET_LED, M_ACK, 1'b1);
    wait_fall(4);
    chk("busy_mid_frame", 32'(busy), 32'd1);
    din   = 8'h55;
    wr_en = 1'b1;
    @(negedge reloj);
    wr_en = 1'b0;
    wait_done(8000);
    repeat (200) @(negedge reloj);
    chk("no_extra_frame", 32'(busy), 32'd0);

    // Reset mid-frame aborts silently; a fresh command then works
    send(CMD_SET_LED, M_ACK, 1'b0);
    wait_fall(5);
    reset = 1'b0;
    @(negedge reloj);
    chk_quiet("midreset");
    reset = 1'b1;
    repeat (200) @(negedge reloj);
    send(8'hA3, M_ACK, 1'b1); wait_done(8000);

    // Silent device: timeout measured from the last ps2c_oe release
    send(8'h3C, M_SILENT, 1'b1);
    prev_c = 1'b1;
    t_fall = cyc;
    seen   = 1'b0;
    g      = 0;
    while (!seen && g < 2 * (INH + TO) + 2000) begin
      @(negedge reloj);
      g++;
      if (prev_c && ps2c_oe === 1'b0) t_fall = cyc;
      prev_c = (ps2c_oe === 1'b1);
      if (tx_err === 1'b1) seen = 1'b1;
    end
    chk("timeout_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("timeout_latency", 32'(cyc - t_fall), 32'(TO));
      chk("timeout_c_oe",    32'(ps2c_oe), 32'd0);
      chk("timeout_d_oe",    32'(ps2d_oe), 32'd0);
      chk("timeout_busy",    32'(busy),    32'd0);
    end
    wait_done(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (200000) @(posedge reloj);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
